// File: rtl/tftlcd_rx_if.sv
// Panel-side RGB/DE bus and the capture results of tftlcd_rx, bundled for bench and integration use.
// The modports describe the direction of each group as seen from the panel driver and from the receiver.
interface tftlcd_rx_if;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        DEN;
    logic        STBYB;

    logic [23:0] o_RGB;
    logic        o_Valid;
    logic [15:0] o_XPx;
    logic [15:0] o_YPx;
    logic        o_SOF;
    logic        o_EOL;
    logic        o_EOF;
    logic        o_LineErr;
    logic        o_FrameErr;
    logic        o_Locked;

    modport master (
        output R, G, B, DEN, STBYB,
        input  o_RGB, o_Valid, o_XPx, o_YPx, o_SOF, o_EOL, o_EOF,
               o_LineErr, o_FrameErr, o_Locked
    );

    modport slave (
        input  R, G, B, DEN, STBYB,
        output o_RGB, o_Valid, o_XPx, o_YPx, o_SOF, o_EOL, o_EOF,
               o_LineErr, o_FrameErr, o_Locked
    );
endinterface

// File: rtl/tftlcd_rx.sv
// DE-mode TFT LCD pixel receiver: locks on a long vertical blank, emits pixels with coordinates,
// and checks every line and frame against the expected H_ACTIVE x V_ACTIVE geometry.
module tftlcd_rx #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned VBLANK_MIN = 3000
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    input  logic        DEN,
    input  logic        STBYB,
    output logic [23:0] o_RGB,
    output logic        o_Valid,
    output logic [15:0] o_XPx,
    output logic [15:0] o_YPx,
    output logic        o_SOF,
    output logic        o_EOL,
    output logic        o_EOF,
    output logic        o_LineErr,
    output logic        o_FrameErr,
    output logic        o_Locked
);

    localparam int unsigned CW      = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_LEN   = 16'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LEN   = 16'(V_ACTIVE);
    localparam logic [CW-1:0] VB_LEN  = 16'(VBLANK_MIN);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_ARMED  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    // Input sampling stage; in_vld_q masks the reset value of the stage on the first edge.
    logic [23:0] rgb_q;
    logic        den_q;
    logic        den_d1_q;
    logic        stbyb_q;
    logic        in_vld_q;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            rgb_q    <= '0;
            den_q    <= 1'b0;
            den_d1_q <= 1'b0;
            stbyb_q  <= 1'b0;
            in_vld_q <= 1'b0;
        end else begin
            rgb_q    <= {R, G, B};
            den_q    <= DEN;
            den_d1_q <= den_q;
            stbyb_q  <= STBYB;
            in_vld_q <= 1'b1;
        end
    end

    state_t        state_q, state_d;
    logic [CW-1:0] blank_q, blank_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          locked_q, locked_d;

    logic [23:0]   out_rgb_q, out_rgb_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] out_x_q, out_x_d;
    logic [CW-1:0] out_y_q, out_y_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eol_q, out_eol_d;
    logic          out_eof_q, out_eof_d;
    logic          out_lerr_q, out_lerr_d;
    logic          out_ferr_q, out_ferr_d;

    logic          rise_c;
    logic          fall_c;
    logic          standby_c;
    logic [CW-1:0] blank_nxt_c;
    logic          gap_done_c;
    logic          emit_c;
    logic [CW-1:0] emit_x_c;
    logic [CW-1:0] emit_y_c;

    assign rise_c      = in_vld_q & den_q & ~den_d1_q;
    assign fall_c      = in_vld_q & ~den_q & den_d1_q;
    assign standby_c   = in_vld_q & ~stbyb_q;
    assign blank_nxt_c = den_q ? '0 : sat_inc(blank_q);
    assign gap_done_c  = (blank_nxt_c == VB_LEN);

    // State register
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= S_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a frame close outranks a line start in the same cycle
    always_comb begin
        state_d = state_q;
        if (in_vld_q) begin
            if (standby_c) begin
                state_d = S_SEARCH;
            end else begin
                case (state_q)
                    S_SEARCH: if (gap_done_c) state_d = S_ARMED;
                    S_ARMED:  if (rise_c)     state_d = S_ACTIVE;
                    S_ACTIVE: if (gap_done_c) state_d = rise_c ? S_ACTIVE : S_ARMED;
                    default:                  state_d = S_SEARCH;
                endcase
            end
        end
    end

    // Counters, frame checks and registered pixel outputs
    always_comb begin
        blank_d    = blank_q;
        x_d        = x_q;
        y_d        = y_q;
        locked_d   = locked_q;
        emit_c     = 1'b0;
        emit_x_c   = '0;
        emit_y_c   = '0;
        out_eof_d  = 1'b0;
        out_ferr_d = 1'b0;
        out_lerr_d = 1'b0;

        if (in_vld_q) begin
            if (standby_c) begin
                blank_d  = '0;
                x_d      = '0;
                y_d      = '0;
                locked_d = 1'b0;
            end else begin
                blank_d = blank_nxt_c;
                case (state_q)
                    S_ACTIVE: begin
                        if (gap_done_c) begin
                            out_eof_d  = (y_q == V_LEN);
                            out_ferr_d = (y_q != V_LEN);
                            locked_d   = (y_q == V_LEN);
                            x_d        = '0;
                            y_d        = '0;
                            emit_c     = rise_c;
                        end else begin
                            if (fall_c) begin
                                y_d        = sat_inc(y_q);
                                out_lerr_d = (x_q != H_LEN);
                            end
                            emit_c   = den_q;
                            emit_x_c = rise_c ? '0 : x_q;
                            emit_y_c = y_q;
                        end
                    end
                    S_ARMED: begin
                        x_d    = '0;
                        y_d    = '0;
                        emit_c = rise_c;
                    end
                    default: begin
                        x_d = '0;
                        y_d = '0;
                    end
                endcase
            end
        end

        if (emit_c) begin
            x_d = sat_inc(emit_x_c);
        end

        out_valid_d = emit_c;
        out_rgb_d   = emit_c ? rgb_q : '0;
        out_x_d     = emit_x_c;
        out_y_d     = emit_y_c;
        out_sof_d   = emit_c && (emit_x_c == '0) && (emit_y_c == '0);
        out_eol_d   = emit_c && (emit_x_c == H_LAST);
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            blank_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            locked_q    <= 1'b0;
            out_rgb_q   <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_lerr_q  <= 1'b0;
            out_ferr_q  <= 1'b0;
        end else begin
            blank_q     <= blank_d;
            x_q         <= x_d;
            y_q         <= y_d;
            locked_q    <= locked_d;
            out_rgb_q   <= out_rgb_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            out_lerr_q  <= out_lerr_d;
            out_ferr_q  <= out_ferr_d;
        end
    end

    assign o_RGB      = out_rgb_q;
    assign o_Valid    = out_valid_q;
    assign o_XPx      = out_x_q;
    assign o_YPx      = out_y_q;
    assign o_SOF      = out_sof_q;
    assign o_EOL      = out_eol_q;
    assign o_EOF      = out_eof_q;
    assign o_LineErr  = out_lerr_q;
    assign o_FrameErr = out_ferr_q;
    assign o_Locked   = locked_q;

endmodule
